// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard unit slice.
// Holds the forwarding select encodings, the divide stall FSM state type,
// the default divide latency and a small helper that turns the per-stage
// match results into an execute-stage forwarding select.
package hazard_unit_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_W  = 2'b01;  // operand from writeback result
  localparam logic [1:0] FWD_M  = 2'b10;  // operand from memory-stage ALU result

  localparam int DIV_CYCLES_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } divState_t;

  // The memory stage holds the younger result, so it wins over writeback.
  function automatic logic [1:0] fwdSelect(input logic hitM, input logic hitW);
    if (hitM) begin
      return FWD_M;
    end else if (hitW) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of the per-stage control bits and register specifiers the hazard
// unit consumes, and the forwarding/stall/flush/redirect signals it returns.
//   slave  : the hazard unit side (control/specifiers in, responses out)
//   master : the controller/datapath side (control/specifiers out, responses in)
interface hazard_unit_if #(
  parameter int REG_AW = 5
);

  logic [REG_AW-1:0] rsD, rtD;
  logic [REG_AW-1:0] rsE, rtE;
  logic [REG_AW-1:0] writeregE, writeregM, writeregW;
  logic              regwriteE, regwriteM, regwriteW;
  logic              memtoregE, memtoregM;
  logic              branchD;
  logic              div_startE;
  logic              overflowE;

  logic              forwardAD, forwardBD;
  logic [1:0]        forwardAE, forwardBE;
  logic              stallF, stallD, stallE;
  logic              flushD, flushE;
  logic              div_done;
  logic              exc_redirectF;

  modport slave (
    input  rsD, rtD, rsE, rtE,
    input  writeregE, writeregM, writeregW,
    input  regwriteE, regwriteM, regwriteW,
    input  memtoregE, memtoregM, branchD,
    input  div_startE, overflowE,
    output forwardAD, forwardBD, forwardAE, forwardBE,
    output stallF, stallD, stallE, flushD, flushE,
    output div_done, exc_redirectF
  );

  modport master (
    output rsD, rtD, rsE, rtE,
    output writeregE, writeregM, writeregW,
    output regwriteE, regwriteM, regwriteW,
    output memtoregE, memtoregM, branchD,
    output div_startE, overflowE,
    input  forwardAD, forwardBD, forwardAE, forwardBE,
    input  stallF, stallD, stallE, flushD, flushE,
    input  div_done, exc_redirectF
  );

endinterface

// File: rtl/hazard_unit_div_stall_fsm.sv
// Multi-cycle divide stall sequencer.
// A DIV/DIVU stays in execute for DIV_CYCLES cycles: the IDLE cycle it is
// first seen in, DIV_CYCLES-2 BUSY cycles, and one DONE cycle in which the
// result is valid and the divide leaves execute.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   divStart   : DIV/DIVU present in execute
//   overflow   : overflow exception in execute (blocks a start)
//   divStall   : hold the front of the pipe while the divide runs
//   divDone    : one-cycle pulse, quotient/remainder valid
module hazard_unit_div_stall_fsm
  import hazard_unit_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic divStart,
  input  logic overflow,
  output logic divStall,
  output logic divDone
);

  localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  divState_t        stateReg, stateNext;
  logic [CNT_W-1:0] cntReg, cntNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    case (stateReg)
      IDLE: begin
        if (divStart && !overflow) begin
          // With only two cycles in execute there is no BUSY phase at all.
          if (DIV_CYCLES == 2) begin
            stateNext = DONE;
          end else begin
            stateNext = BUSY;
            cntNext   = START_CNT;
          end
        end
      end
      BUSY: begin
        // Leave on the cycle the count reaches zero, so BUSY lasts
        // exactly DIV_CYCLES-2 cycles.
        cntNext = cntReg - CNT_ONE;
        if (cntReg <= CNT_ONE) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        // A divStart still high here belongs to the finishing divide.
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  always_comb begin
    divStall = 1'b0;
    divDone  = 1'b0;
    if (!rst) begin
      divStall = (stateReg == BUSY) || ((stateReg == IDLE) && divStart);
      divDone  = (stateReg == DONE);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard responder for the 5-stage MIPS core.
// Produces execute/decode forwarding selects, the load-use, branch and
// divide stalls, the execute flush, and the overflow exception redirect.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   hz       : hazard_unit_if.slave bundle (per-stage control and register
//              specifiers in; forwardAE/BE/AD/BD, stallF/D/E, flushD/E,
//              div_done, exc_redirectF out)
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int REG_AW     = 5
) (
  input  logic          clk,
  input  logic          rst,
  hazard_unit_if.slave  hz
);

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  logic lwStall;
  logic branchStall;
  logic divStall;
  logic divDone;
  logic excRedirectReg;

  logic [1:0] fwdAE, fwdBE;
  logic       fwdAD, fwdBD;

  // Forwarding: register 0 is hard-wired, so it never takes a bypass.
  always_comb begin
    fwdAE = fwdSelect(
      (hz.rsE != REG_ZERO) && hz.regwriteM && (hz.rsE == hz.writeregM),
      (hz.rsE != REG_ZERO) && hz.regwriteW && (hz.rsE == hz.writeregW));
    fwdBE = fwdSelect(
      (hz.rtE != REG_ZERO) && hz.regwriteM && (hz.rtE == hz.writeregM),
      (hz.rtE != REG_ZERO) && hz.regwriteW && (hz.rtE == hz.writeregW));
    fwdAD = (hz.rsD != REG_ZERO) && hz.regwriteM && (hz.rsD == hz.writeregM);
    fwdBD = (hz.rtD != REG_ZERO) && hz.regwriteM && (hz.rtD == hz.writeregM);
  end

  // Stall terms. A load or ALU result headed for register 0 is discarded,
  // so it cannot be the source of a hazard.
  always_comb begin
    lwStall = hz.memtoregE && (hz.rtE != REG_ZERO) &&
              ((hz.rtE == hz.rsD) || (hz.rtE == hz.rtD));
    branchStall = hz.branchD && (
      (hz.regwriteE && (hz.writeregE != REG_ZERO) &&
       ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD))) ||
      (hz.memtoregM && (hz.writeregM != REG_ZERO) &&
       ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD))));
  end

  hazard_unit_div_stall_fsm #(
    .DIV_CYCLES (DIV_CYCLES)
  ) divStallFsm (
    .clk      (clk),
    .rst      (rst),
    .divStart (hz.div_startE),
    .overflow (hz.overflowE),
    .divStall (divStall),
    .divDone  (divDone)
  );

  // The redirect goes to the PC one cycle after the overflowing instruction
  // is flushed out of execute.
  always_ff @(posedge clk) begin
    if (rst) begin
      excRedirectReg <= 1'b0;
    end else begin
      excRedirectReg <= hz.overflowE;
    end
  end

  always_comb begin
    hz.forwardAE = FWD_RF;
    hz.forwardBE = FWD_RF;
    hz.forwardAD = 1'b0;
    hz.forwardBD = 1'b0;
    hz.stallF    = 1'b0;
    hz.stallD    = 1'b0;
    hz.stallE    = 1'b0;
    hz.flushD    = 1'b0;
    hz.flushE    = 1'b0;
    if (!rst) begin
      hz.forwardAE = fwdAE;
      hz.forwardBE = fwdBE;
      hz.forwardAD = fwdAD;
      hz.forwardBD = fwdBD;
      if (hz.overflowE) begin
        // Exception squashes the faulting instruction and everything
        // younger; nothing may hold the pipe while the vector is fetched.
        hz.flushD = 1'b1;
        hz.flushE = 1'b1;
      end else begin
        hz.stallF = lwStall | branchStall | divStall;
        hz.stallD = lwStall | branchStall | divStall;
        hz.stallE = divStall;
        // Flushing ID/EX while the divide holds it would lose the divide.
        hz.flushE = (lwStall | branchStall) & ~divStall;
      end
    end
  end

  assign hz.div_done      = divDone;
  assign hz.exc_redirectF = excRedirectReg;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit with DIV_CYCLES=4.
// Each vector is applied just after a rising edge; its hand-computed
// response is queued, and the monitor checks it at the following falling
// edge.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_unit_if #(.REG_AW(5)) hz ();

  hazard_unit #(
    .DIV_CYCLES (4),
    .REG_AW     (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  typedef struct {
    string      name;
    logic [12:0] exp;
  } sbItem_t;

  sbItem_t sbQ[$];
  int vectors     = 0;
  int miscompares = 0;

  // {forwardAE, forwardBE, forwardAD, forwardBD, stallF, stallD, stallE,
  //  flushD, flushE, div_done, exc_redirectF}
  function automatic logic [12:0] ex(
    input logic [1:0] fAE, input logic [1:0] fBE,
    input logic fAD, input logic fBD,
    input logic sF, input logic sD, input logic sE,
    input logic fD, input logic fE,
    input logic dd, input logic er);
    return {fAE, fBE, fAD, fBD, sF, sD, sE, fD, fE, dd, er};
  endfunction

  always @(negedge clk) begin
    if (sbQ.size() > 0) begin
      sbItem_t item;
      logic [12:0] act;
      item = sbQ.pop_front();
      act = {hz.forwardAE, hz.forwardBE, hz.forwardAD, hz.forwardBD,
             hz.stallF, hz.stallD, hz.stallE, hz.flushD, hz.flushE,
             hz.div_done, hz.exc_redirectF};
      vectors++;
      if (act !== item.exp) begin
        miscompares++;
        $display("FAIL %s: got %b expected %b", item.name, act, item.exp);
      end else begin
        $display("vec %-14s ok  outputs=%b", item.name, act);
      end
    end
  end

  task automatic clr();
    hz.rsD = '0; hz.rtD = '0; hz.rsE = '0; hz.rtE = '0;
    hz.writeregE = '0; hz.writeregM = '0; hz.writeregW = '0;
    hz.regwriteE = 1'b0; hz.regwriteM = 1'b0; hz.regwriteW = 1'b0;
    hz.memtoregE = 1'b0; hz.memtoregM = 1'b0; hz.branchD = 1'b0;
    hz.div_startE = 1'b0; hz.overflowE = 1'b0;
  endtask

  task automatic step(input string name, input logic [12:0] exp);
    sbItem_t item;
    item.name = name;
    item.exp  = exp;
    sbQ.push_back(item);
    @(posedge clk);
    #1;
  endtask

  task automatic lwUse();
    hz.memtoregE = 1'b1; hz.rtE = 5'd9; hz.rsD = 5'd9;
  endtask

  initial begin
    int waitCycles;
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset holds every combinational response low despite live hazards.
    clr(); lwUse(); hz.regwriteM = 1'b1; hz.writeregM = 5'd8; hz.rsE = 5'd8;
    step("rst_gate", ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    clr();
    step("idle", ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Forwarding
    clr(); hz.writeregM = 5'd8; hz.regwriteM = 1'b1;
    hz.writeregW = 5'd8; hz.regwriteW = 1'b1; hz.rsE = 5'd8;
    step("fwdA_M", ex(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    hz.regwriteM = 1'b0;
    step("fwdA_W", ex(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    hz.regwriteM = 1'b1; hz.rsE = 5'd0; hz.rtE = 5'd8;
    step("fwdA_r0_B_M", ex(2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    hz.regwriteM = 1'b0; hz.rsE = 5'd3;
    step("fwdB_W", ex(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Load-use
    clr(); lwUse();
    step("lw_use", ex(2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 1, 0, 0));
    clr(); hz.memtoregE = 1'b1; hz.rtE = 5'd9; hz.rsD = 5'd10; hz.rtD = 5'd11;
    step("lw_none", ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    clr(); hz.memtoregE = 1'b1; hz.rtE = 5'd0; hz.rsD = 5'd0;
    step("lw_r0", ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Branch
    clr(); hz.branchD = 1'b1; hz.regwriteE = 1'b1; hz.writeregE = 5'd4; hz.rsD = 5'd4;
    step("br_E", ex(2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 1, 0, 0));
    clr(); hz.branchD = 1'b1; hz.memtoregM = 1'b1; hz.writeregM = 5'd4; hz.rsD = 5'd4;
    step("br_M_load", ex(2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 1, 0, 0));
    clr(); hz.branchD = 1'b1; hz.regwriteM = 1'b1; hz.writeregM = 5'd4; hz.rsD = 5'd4;
    step("br_fwdAD", ex(2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    hz.rsD = 5'd5; hz.rtD = 5'd4;
    step("br_fwdBD", ex(2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    // Overflow overrides the load-use stall, redirect follows one cycle later
    clr(); lwUse(); hz.overflowE = 1'b1;
    step("ovf", ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    clr();
    step("ovf_redir", ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step("ovf_redir_off", ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Divide, div_startE held for the four execute cycles
    clr(); hz.div_startE = 1'b1;
    step("div_c0", ex(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    lwUse();
    step("div_c1_lw", ex(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    clr(); hz.div_startE = 1'b1;
    step("div_c2", ex(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    step("div_c3_done", ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    clr();
    step("div_c4_idle", ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    lwUse();
    step("lw_after_div", ex(2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 1, 0, 0));

    // Overflow alongside a divide start: no divide begins
    clr(); hz.div_startE = 1'b1; hz.overflowE = 1'b1;
    step("ovf_div", ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    clr();
    step("ovf_div_after", ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Reset in the last BUSY cycle abandons the divide
    clr(); hz.div_startE = 1'b1;
    step("rd_c0", ex(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    clr();
    step("rd_busy2", ex(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    rst = 1'b1;
    step("rd_rst_busy1", ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    step("rd_no_done", ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("rd_idle", ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    hz.div_startE = 1'b1;
    step("rs_c0", ex(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    clr();
    step("rs_c1", ex(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    step("rs_c2", ex(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    step("rs_c3_done", ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step("rs_c4_idle", ex(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    waitCycles = 0;
    while (sbQ.size() != 0 && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    #1;
    if (sbQ.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", sbQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard responder for the 5-stage MIPS core.
- Consumes the per-stage control bits the controller emits (regwrite/memtoreg E/M/W, branchD) plus register specifiers from the datapath.
- Returns forwarding selects and the stall/flush signals that the controller and datapath pipeline registers consume (including flushE).
- Owns the sequential multi-cycle divide stall FSM and the one-cycle overflow exception redirect.

Parameters:
- DIV_CYCLES, 32: execute-stage cycles a DIV/DIVU occupies; must be >= 2.
- REG_AW, 5: register specifier width.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous active-high reset.
- rsD, rtD, input, REG_AW each: decode-stage source registers.
- rsE, rtE, input, REG_AW each: execute-stage source registers.
- writeregE, writeregM, writeregW, input, REG_AW each: destination register per stage.
- regwriteE, regwriteM, regwriteW, input, 1 each: write enable per stage.
- memtoregE, memtoregM, input, 1 each: load in stage.
- branchD, input, 1: branch in decode.
- div_startE, input, 1: DIV/DIVU in execute.
- overflowE, input, 1: arithmetic overflow in execute.
- forwardAD, forwardBD, output, 1 each: decode-compare operand from M.
- forwardAE, forwardBE, output, 2 each: 00 register file, 01 from W, 10 from M.
- stallF, stallD, stallE, output, 1 each: hold PC / IF-ID / ID-EX.
- flushD, flushE, output, 1 each: clear IF-ID / ID-EX.
- div_done, output, 1: one-cycle pulse, quotient/remainder valid for hilo write.
- exc_redirectF, output, 1: registered; selects the exception vector into the PC.

Behaviour:
- Forwarding (combinational):
  - forwardAE = 10 if rsE!=0 && regwriteM && rsE==writeregM.
  - Else 01 if rsE!=0 && regwriteW && rsE==writeregW.
  - Else 00. M has priority over W. forwardBE is the same with rtE.
  - forwardAD = rsD!=0 && regwriteM && rsD==writeregM. forwardBD is the same with rtD.
- Stall terms:
  - lwstall = memtoregE && (rtE==rsD || rtE==rtD).
  - branchstall = branchD && ((regwriteE && writeregE∈{rsD,rtD}) || (memtoregM && writeregM∈{rsD,rtD})).
  - Register 0 is never a hazard source.
- Divide FSM, states IDLE, BUSY, DONE; counter width clog2(DIV_CYCLES):
  - IDLE with div_startE=1 and overflowE=0: go to BUSY, cnt<=DIV_CYCLES-2.
  - BUSY: cnt decrements each cycle; at cnt==0 go to DONE.
  - DONE: div_done=1 for exactly one cycle, then IDLE.
  - divstall = (state==BUSY) || (state==IDLE && div_startE).
  - Total cycles the divide stays in E = DIV_CYCLES; stall asserted DIV_CYCLES-1 of them.
  - In DONE the divide leaves E. div_startE still high that cycle does not retrigger, because the DONE->IDLE transition ignores it.
- Output equations:
  - stallF = stallD = lwstall | branchstall | divstall.
  - stallE = divstall.
  - flushE = (lwstall | branchstall) & ~divstall.
  - flushD = 0, except during an overflow.
- Overflow:
  - overflowE=1 forces flushD=1, flushE=1, stallF=stallD=stallE=0, overriding all stall terms.
  - exc_redirectF <= 1 on the next edge, held for exactly one cycle.
  - Overflow cannot coincide with div_startE (different instruction classes). If both are seen anyway, overflow wins and the FSM stays IDLE.
- Reset:
  - On rst=1 at an edge: state=IDLE, cnt=0, exc_redirectF=0, div_done=0.
  - While rst=1, all stall/flush/forward outputs are driven 0.
  - Reset mid-divide abandons the divide with no div_done pulse.
- Simultaneous events:
  - lwstall during divstall: stall stays, flushE is suppressed so the divide is not lost.
  - The load-use hazard is re-evaluated after DONE.

Decomposition:
- Shared package/defines file:
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - Divide FSM state encodings IDLE/BUSY/DONE.
  - DIV_CYCLES default.
- One natural sub-module: div_stall_fsm. It holds the state, counter, divstall and div_done. Forwarding and stall logic stay in hazard_unit.

Test Plan:
- Forwarding: writeregM=8, regwriteM=1, writeregW=8, regwriteW=1, rsE=8 -> forwardAE=10. With regwriteM=0 -> 01. With rsE=0 -> 00.
- Load-use: memtoregE=1, rtE=9, rsD=9 -> stallF=stallD=1, flushE=1, stallE=0 for one cycle. With rsD=10, rtD=11 -> all 0.
- Branch: branchD=1, regwriteE=1, writeregE=4, rsD=4 -> stall 1 cycle. Next cycle memtoregM=1, writeregM=4 -> stall again. Then forwardAD=1 when regwriteM=1.
- Divide, DIV_CYCLES=4, div_startE held high:
  - stallE=1 for cycles 0–2, div_done=1 on cycle 3 with stallE=0.
  - FSM back in IDLE on cycle 4; no second pulse.
- Overflow: overflowE=1 with lwstall conditions present -> flushD=flushE=1, stalls 0. exc_redirectF=1 the next cycle only.
- Reset mid-divide: rst=1 at BUSY cnt=1 -> next cycle IDLE, stalls 0, no div_done. Fresh div_startE restarts the full DIV_CYCLES count.
